// File: rtl/mux253_pkg.sv
// Shared types and constants for the dual 4:1 selector scan sequencer.
package mux253_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Channels per mux half and width of the assembled snapshot.
    localparam int NUM_CH = 4;
    localparam int SNAP_W = 8;

endpackage

// File: rtl/mux253_settle_timer.sv
// Settle timer: loads SETTLE_CYCLES-1, counts down on request, flags zero.
// The zero flag reflects the registered count, so a load of SETTLE_CYCLES-1
// yields exactly SETTLE_CYCLES cycles before the flag is seen.
module mux253_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int              CW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]   LOAD_VAL = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load has priority, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux253_scan_ctrl.sv
// Scan sequencer for a 74LS253-style dual 4:1 selector. Walks the shared
// selects through channels 0..3, waits SETTLE_CYCLES at each, samples both
// halves and publishes an 8-bit snapshot with a start/busy/done handshake.
// Optional macro MUX253_SCAN_CHG_EN adds a 'chg' pulse alongside 'done'
// when the new snapshot differs from the previous data_out.
module mux253_scan_ctrl
    import mux253_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        chan_mask,
    input  logic              y1,
    input  logic              y2,
    output logic              sel_a,
    output logic              sel_b,
    output logic [1:0]        en_n,
    output logic              busy,
    output logic              done,
    output logic [SNAP_W-1:0] data_out
`ifdef MUX253_SCAN_CHG_EN
    ,
    output logic              chg
`endif
);

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [1:0]          mask_q, mask_d;
    logic [SNAP_W-1:0]   shadow_q, shadow_d;
    logic [SNAP_W-1:0]   data_q, data_d;
    logic [1:0]          sel_q, sel_d;
    logic [1:0]          en_n_q, en_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef MUX253_SCAN_CHG_EN
    logic                chg_q, chg_d;
`endif

    logic                tmr_load;
    logic                tmr_dec;
    logic                tmr_zero;

    mux253_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .dec_i  (tmr_dec),
        .zero_o (tmr_zero)
    );

    // Next-state, capture and registered-output decode; outputs follow the
    // next state so they line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
`ifdef MUX253_SCAN_CHG_EN
        chg_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d   = chan_mask;
                    idx_d    = 2'd0;
                    shadow_d = '0;
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_d = SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            SAMPLE: begin
                // Disabled halves read as zero regardless of the pin level.
                shadow_d[{1'b0, idx_q}] = y1 & mask_q[0];
                shadow_d[{1'b1, idx_q}] = y2 & mask_q[1];
                if (idx_q == 2'(NUM_CH - 1)) begin
                    data_d  = shadow_d;
`ifdef MUX253_SCAN_CHG_EN
                    chg_d   = (shadow_d != data_q);
`endif
                    state_d = DONE;
                end else begin
                    idx_d    = idx_q + 2'd1;
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
        en_n_d = busy_d ? ~mask_d : 2'b11;
        // Selects move only when a new SETTLE begins; held otherwise.
        sel_d  = (state_d == SETTLE) ? idx_d : sel_q;
    end

    // State and registered outputs; reset aborts any scan in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            mask_q   <= 2'b00;
            shadow_q <= '0;
            data_q   <= '0;
            sel_q    <= 2'b00;
            en_n_q   <= 2'b11;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MUX253_SCAN_CHG_EN
            chg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            en_n_q   <= en_n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MUX253_SCAN_CHG_EN
            chg_q    <= chg_d;
`endif
        end
    end

    assign sel_a    = sel_q[0];
    assign sel_b    = sel_q[1];
    assign en_n     = en_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_q;
`ifdef MUX253_SCAN_CHG_EN
    assign chg      = chg_q;
`endif

endmodule

// File: tb/tb_mux253_scan_ctrl.sv
// Bench for mux253_scan_ctrl: a dual 4:1 mux model closes the loop from
// sel/en_n back to y1/y2; expected snapshots are queued when a scan starts
// and popped when done pulses. A second instance runs with SETTLE_CYCLES=1.
module tb_mux253_scan_ctrl;

    localparam int S   = 2;
    localparam int S1  = 1;
    localparam int LAT = 4 * (S + 1);
    localparam int LAT1 = 4 * (S1 + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, y1, y2, sel_a, sel_b, busy, done;
    logic [1:0] chan_mask, en_n;
    logic [7:0] data_out;
    logic [3:0] d1, d2;

    logic       start_s1, y1_s1, y2_s1, sel_a_s1, sel_b_s1, busy_s1, done_s1;
    logic [1:0] mask_s1, en_n_s1;
    logic [7:0] data_s1;
    logic [3:0] d1_s1, d2_s1;
`ifdef MUX253_SCAN_CHG_EN
    logic       chg, chg_s1;
`endif

    // Dual 4:1 mux model; a disabled half drives 0.
    assign y1    = en_n[0]    ? 1'b0 : d1[{sel_b, sel_a}];
    assign y2    = en_n[1]    ? 1'b0 : d2[{sel_b, sel_a}];
    assign y1_s1 = en_n_s1[0] ? 1'b0 : d1_s1[{sel_b_s1, sel_a_s1}];
    assign y2_s1 = en_n_s1[1] ? 1'b0 : d2_s1[{sel_b_s1, sel_a_s1}];

    mux253_scan_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .chan_mask(chan_mask),
        .y1(y1), .y2(y2), .sel_a(sel_a), .sel_b(sel_b), .en_n(en_n),
        .busy(busy), .done(done), .data_out(data_out)
`ifdef MUX253_SCAN_CHG_EN
        , .chg(chg)
`endif
    );

    mux253_scan_ctrl #(.SETTLE_CYCLES(S1)) dut_s1 (
        .clk(clk), .rst(rst), .start(start_s1), .chan_mask(mask_s1),
        .y1(y1_s1), .y2(y2_s1), .sel_a(sel_a_s1), .sel_b(sel_b_s1), .en_n(en_n_s1),
        .busy(busy_s1), .done(done_s1), .data_out(data_s1)
`ifdef MUX253_SCAN_CHG_EN
        , .chg(chg_s1)
`endif
    );

    typedef struct {
        logic [7:0] data;
        logic       chg;
        int         cyc;
    } exp_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_done = 0;
    int         cyc = 0;
    logic [7:0] prev_exp = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] snap(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
        return {b & {4{m[1]}}, a & {4{m[0]}}};
    endfunction

    task automatic push_exp(input logic [7:0] v, input int at);
        exp_t e;
        e.data = v;
        e.chg  = (v != prev_exp);
        e.cyc  = at;
        prev_exp = v;
        sbq.push_back(e);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sbq.size() == 0) begin
                chk("done_unexpected", {31'b0, done}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("data_out", {24'b0, data_out}, {24'b0, mon_e.data});
`ifdef MUX253_SCAN_CHG_EN
                chk("chg", {31'b0, chg}, {31'b0, mon_e.chg});
`endif
            end
        end
    end

    task automatic do_start(output int e_cyc);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        e_cyc = cyc;
    endtask

    // One scan; optional stray start pulse at pulse_k and mask change mid-scan.
    task automatic scan(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                        input int pulse_k, input bit mask_flip);
        int         e;
        logic [1:0] en_exp;
        logic       busy_exp;
        d1 = a; d2 = b; chan_mask = m;
        do_start(e);
        push_exp(snap(m, a, b), e + LAT);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            busy_exp = (k < LAT);
            en_exp   = busy_exp ? ~m : 2'b11;
            chk("busy", {31'b0, busy}, {31'b0, busy_exp});
            chk("en_n", {30'b0, en_n}, {30'b0, en_exp});
            start = (k == pulse_k);
            if (mask_flip && k == 3) chan_mask = ~m;
        end
        @(negedge clk);
        start = 1'b0;
        chk("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    // Start held high: DONE, one IDLE cycle, then the next scan is accepted.
    task automatic held3(input logic [3:0] a, input logic [3:0] b);
        int e;
        d1 = a; d2 = b; chan_mask = 2'b11;
        @(negedge clk) start = 1'b1;
        @(negedge clk) e = cyc;
        for (int i = 0; i < 3; i++) push_exp(snap(2'b11, a, b), e + LAT + i * (LAT + 2));
        for (int k = 1; k <= 3 * LAT + 4; k++) begin
            @(negedge clk);
            if (k == LAT + 1) begin
                chk("gap_busy", {31'b0, busy}, 32'd0);
                chk("gap_en_n", {30'b0, en_n}, 32'd3);
            end
            if (k == LAT + 2) chk("rearm_busy", {31'b0, busy}, 32'd1);
        end
        start = 1'b0;
        repeat (LAT + 4) @(negedge clk);
    endtask

    task automatic reset_mid();
        int e;
        d1 = 4'b1010; d2 = 4'b0110; chan_mask = 2'b11;
        do_start(e);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prev_exp = 8'h00;
        chk("rst_en_n", {30'b0, en_n}, 32'd3);
        chk("rst_data", {24'b0, data_out}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sel", {30'b0, sel_b, sel_a}, 32'd0);
        repeat (LAT + 2) @(negedge clk);
    endtask

    // SETTLE_CYCLES=1 instance: D1 ch1 changes during its SETTLE step.
    task automatic settle1_scan();
        int         e;
        logic       busy_exp, done_exp;
        d1_s1 = 4'b1010; d2_s1 = 4'b0110; mask_s1 = 2'b11;
        @(negedge clk) start_s1 = 1'b1;
        @(negedge clk) start_s1 = 1'b0;
        e = cyc;
        for (int k = 1; k <= LAT1 + 1; k++) begin
            @(negedge clk);
            busy_exp = (k < LAT1);
            done_exp = (k == LAT1);
            chk("s1_busy", {31'b0, busy_s1}, {31'b0, busy_exp});
            chk("s1_done", {31'b0, done_s1}, {31'b0, done_exp});
            if (k == 2) d1_s1 = 4'b1000;
            if (k == LAT1) chk("s1_data", {24'b0, data_s1}, 32'h68);
        end
        chk("s1_elapsed", cyc - e, LAT1 + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; chan_mask = 2'b00; d1 = 4'h0; d2 = 4'h0;
        start_s1 = 1'b0; mask_s1 = 2'b00; d1_s1 = 4'h0; d2_s1 = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset_en_n", {30'b0, en_n}, 32'd3);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_data", {24'b0, data_out}, 32'd0);
        chk("reset_sel", {30'b0, sel_b, sel_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        scan(2'b11, 4'b1010, 4'b0110, 0, 1'b1);   // 6A, mask changed mid-scan
        scan(2'b01, 4'b1010, 4'b0110, 0, 1'b0);   // 0A
        scan(2'b00, 4'b1010, 4'b0110, 0, 1'b0);   // 00, full length
        scan(2'b11, 4'b1010, 4'b0110, 5, 1'b0);   // stray start ignored
        held3(4'b1010, 4'b0110);
        reset_mid();
        scan(2'b11, 4'b1010, 4'b0110, 0, 1'b0);   // fresh scan after reset
        scan(2'b11, 4'b1010, 4'b0110, 0, 1'b0);   // unchanged snapshot
        scan(2'b11, 4'b1010, 4'b1110, 0, 1'b0);   // D2 ch3 flipped -> EA
        repeat (4) @(negedge clk);

        chk("sb_empty", sbq.size(), 32'd0);
        chk("done_count", n_done, 32'd10);

        settle1_scan();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
